uart_tx: RTL and testbench

//   UART transmitter; serialises one parallel word per frame onto the TX line:

---
 rtl/uart_tx_if.sv | 27 ++
 rtl/uart_tx.sv | 139 +++++++++++++
 tb/tb_uart_tx.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_if
//  Purpose  : Host-side word handshake and serial/status lines of uart_tx.
//  Revision : 1.0
// ============================================================================
interface uart_tx_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 tx_out;
  logic                 tx_busy;
  logic                 tx_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, tx_out, tx_busy, tx_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, tx_out, tx_busy, tx_done
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : UART transmitter: start, DATA_BITS LSB first, optional parity, stop.
//  Revision : 1.0
// ============================================================================
module uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic       tx_clk,
  input  logic       tx_rst,
  uart_tx_if.slave   bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] c_cnt_max   = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] c_last_bit  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] c_last_stop = IW'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } t_state;

  t_state                r_state, w_state_nxt;
  logic [CW-1:0]         r_cnt,   w_cnt_nxt;
  logic [IW-1:0]         r_idx,   w_idx_nxt;
  logic [DATA_BITS-1:0]  r_shreg, w_shreg_nxt;
  logic                  r_par,   w_par_nxt;
  logic                  r_tx_out, w_out_nxt;
  logic                  r_done,  w_done_nxt;
  logic                  w_tick;

  assign w_tick = (r_cnt == c_cnt_max);

  always_ff @(posedge tx_clk) begin
    if (tx_rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_idx    <= '0;
      r_shreg  <= '0;
      r_par    <= 1'b0;
      r_tx_out <= 1'b1;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_idx    <= w_idx_nxt;
      r_shreg  <= w_shreg_nxt;
      r_par    <= w_par_nxt;
      r_tx_out <= w_out_nxt;
      r_done   <= w_done_nxt;
    end
  end

  // The line level is computed one cycle ahead so tx_out leaves a flop.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_shreg_nxt = r_shreg;
    w_par_nxt   = r_par;
    w_out_nxt   = r_tx_out;
    w_done_nxt  = 1'b0;

    if (r_state == S_IDLE) begin
      w_cnt_nxt = '0;
      w_idx_nxt = '0;
      w_out_nxt = 1'b1;
      if (bus.tx_valid) begin
        w_state_nxt = S_START;
        w_shreg_nxt = bus.tx_data;
        w_par_nxt   = (^bus.tx_data) ^ (PARITY_ODD != 0);
        w_out_nxt   = 1'b0;
      end
    end else begin
      w_cnt_nxt = w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        case (r_state)
          S_START: begin
            w_state_nxt = S_DATA;
            w_out_nxt   = r_shreg[0];
          end
          S_DATA: begin
            if (r_idx == c_last_bit) begin
              w_idx_nxt = '0;
              if (PARITY_EN != 0) begin
                w_state_nxt = S_PARITY;
                w_out_nxt   = r_par;
              end else begin
                w_state_nxt = S_STOP;
                w_out_nxt   = 1'b1;
              end
            end else begin
              w_idx_nxt   = r_idx + 1'b1;
              w_shreg_nxt = {1'b0, r_shreg[DATA_BITS-1:1]};
              w_out_nxt   = r_shreg[1];
            end
          end
          S_PARITY: begin
            w_state_nxt = S_STOP;
            w_idx_nxt   = '0;
            w_out_nxt   = 1'b1;
          end
          S_STOP: begin
            w_out_nxt = 1'b1;
            if (r_idx == c_last_stop) begin
              w_state_nxt = S_IDLE;
              w_idx_nxt   = '0;
              w_done_nxt  = 1'b1;
            end else begin
              w_idx_nxt = r_idx + 1'b1;
            end
          end
          default: begin
            w_state_nxt = S_IDLE;
            w_out_nxt   = 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.tx_ready = (r_state == S_IDLE);
  assign bus.tx_busy  = (r_state != S_IDLE);
  assign bus.tx_out   = r_tx_out;
  assign bus.tx_done  = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Directed bench for uart_tx over four parameter sets sharing clk/rst.
//  Revision : 1.0
// ============================================================================
module tb_uart_tx;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic [3:0] valid;
  logic [3:0] out, rdy, busy, done;
  int         n_vec;
  int         n_err;
  int         done_cnt [4];

  // 0: base, 1: even parity, 2: odd parity, 3: two stop bits
  uart_tx_if #(.DATA_BITS(8)) if0 ();
  uart_tx_if #(.DATA_BITS(8)) if1 ();
  uart_tx_if #(.DATA_BITS(8)) if2 ();
  uart_tx_if #(.DATA_BITS(8)) if3 ();

  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0))
    u_dut0 (.tx_clk(clk), .tx_rst(rst), .bus(if0.slave));
  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0))
    u_dut1 (.tx_clk(clk), .tx_rst(rst), .bus(if1.slave));
  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1))
    u_dut2 (.tx_clk(clk), .tx_rst(rst), .bus(if2.slave));
  uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0))
    u_dut3 (.tx_clk(clk), .tx_rst(rst), .bus(if3.slave));

  assign if0.tx_data = data;  assign if0.tx_valid = valid[0];
  assign if1.tx_data = data;  assign if1.tx_valid = valid[1];
  assign if2.tx_data = data;  assign if2.tx_valid = valid[2];
  assign if3.tx_data = data;  assign if3.tx_valid = valid[3];

  assign out  = {if3.tx_out,   if2.tx_out,   if1.tx_out,   if0.tx_out};
  assign rdy  = {if3.tx_ready, if2.tx_ready, if1.tx_ready, if0.tx_ready};
  assign busy = {if3.tx_busy,  if2.tx_busy,  if1.tx_busy,  if0.tx_busy};
  assign done = {if3.tx_done,  if2.tx_done,  if1.tx_done,  if0.tx_done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) done_cnt[i] += int'(done[i]);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected line level for frame bit b of word w on DUT idx.
  function automatic logic exp_bit(input int idx, input logic [7:0] w, input int b);
    bit pe, po;
    pe = (idx == 1) || (idx == 2);
    po = (idx == 2);
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    if (pe && b == 9) return (^w) ^ po;
    return 1'b1;
  endfunction

  // Entered at the falling edge right after the accepting rising edge.
  task automatic check_frame(input int idx, input logic [7:0] w, input bit toggle);
    int nb;
    nb = 10 + (((idx == 1) || (idx == 2)) ? 1 : 0) + ((idx == 3) ? 1 : 0);
    for (int c = 0; c < nb * 4; c++) begin
      if (c > 0) @(negedge clk);
      chk($sformatf("d%0d_w%02h_c%0d_out", idx, w, c), {31'd0, out[idx]}, {31'd0, exp_bit(idx, w, c / 4)});
      chk($sformatf("d%0d_w%02h_c%0d_busy", idx, w, c), {31'd0, busy[idx]}, 32'd1);
      chk($sformatf("d%0d_w%02h_c%0d_ready", idx, w, c), {31'd0, rdy[idx]}, 32'd0);
      chk($sformatf("d%0d_w%02h_c%0d_done", idx, w, c), {31'd0, done[idx]}, 32'd0);
      if (toggle) data = ~data;
    end
    @(negedge clk);
    chk($sformatf("d%0d_w%02h_end_done", idx, w), {31'd0, done[idx]}, 32'd1);
    chk($sformatf("d%0d_w%02h_end_ready", idx, w), {31'd0, rdy[idx]}, 32'd1);
    chk($sformatf("d%0d_w%02h_end_busy", idx, w), {31'd0, busy[idx]}, 32'd0);
    chk($sformatf("d%0d_w%02h_end_out", idx, w), {31'd0, out[idx]}, 32'd1);
  endtask

  task automatic send(input int idx, input logic [7:0] w, input bit toggle);
    @(negedge clk);
    data       = w;
    valid[idx] = 1'b1;
    @(negedge clk);
    valid[idx] = 1'b0;
    check_frame(idx, w, toggle);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < 4; i++) done_cnt[i] = 0;
    rst   = 1'b1;
    valid = 4'b0;
    data  = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("idle_d%0d_c%0d_out", i, c), {31'd0, out[i]}, 32'd1);
        chk($sformatf("idle_d%0d_c%0d_ready", i, c), {31'd0, rdy[i]}, 32'd1);
        chk($sformatf("idle_d%0d_c%0d_busy", i, c), {31'd0, busy[i]}, 32'd0);
        chk($sformatf("idle_d%0d_c%0d_done", i, c), {31'd0, done[i]}, 32'd0);
      end
    end

    send(0, 8'hA5, 1'b0);
    send(1, 8'h07, 1'b0);
    send(2, 8'h07, 1'b0);
    send(1, 8'hC3, 1'b0);

    // Back-to-back with valid held: one idle-high cycle between frames
    @(negedge clk);
    data     = 8'h00;
    valid[0] = 1'b1;
    @(negedge clk);
    data = 8'hFF;
    check_frame(0, 8'h00, 1'b0);
    @(negedge clk);
    valid[0] = 1'b0;
    check_frame(0, 8'hFF, 1'b0);

    // Reset during data bit 3 of 0x3C
    @(negedge clk);
    data     = 8'h3C;
    valid[0] = 1'b1;
    @(negedge clk);
    valid[0] = 1'b0;
    repeat (17) @(negedge clk);
    chk("abort_bit3_out", {31'd0, out[0]}, 32'd1);
    chk("abort_bit3_busy", {31'd0, busy[0]}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_out", {31'd0, out[0]}, 32'd1);
    chk("abort_ready", {31'd0, rdy[0]}, 32'd1);
    chk("abort_busy", {31'd0, busy[0]}, 32'd0);
    chk("abort_done", {31'd0, done[0]}, 32'd0);
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      chk($sformatf("post_abort_c%0d_out", c), {31'd0, out[0]}, 32'd1);
      chk($sformatf("post_abort_c%0d_done", c), {31'd0, done[0]}, 32'd0);
    end
    send(0, 8'h81, 1'b0);

    // Two stop bits, tx_data toggled throughout the frame
    send(3, 8'h5A, 1'b1);

    @(negedge clk);
    chk("done_count_d0", done_cnt[0], 32'd4);
    chk("done_count_d1", done_cnt[1], 32'd2);
    chk("done_count_d2", done_cnt[2], 32'd1);
    chk("done_count_d3", done_cnt[3], 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
